// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
//
// Arbitrates a single-port video memory between an MCU write stream and a
// scanout read requester. MCU bytes arrive as strobes: cmdclk loads a start
// address, each dataclk queues one byte at the running write pointer, which
// then advances. Queued writes drain to memory whenever scanout is not asking.
// Scanout reads take priority over queued writes.
//
// Optional feature (macro VRAM_ARB_STARVE_GUARD_EN): a starvation guard that
// forces one queued write after STARVE_LIMIT consecutive completed reads while
// writes are waiting. Without the macro, reads have strict priority.
//
// Ports:
//   sysclk     in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   cmdclk     in   strobe: address is valid
//   address    in   [31:0] MCU start address, low ADDR_W bits used
//   dataclk    in   strobe: data_in is valid
//   data_in    in   [7:0] MCU pixel byte
//   scan_req   in   scanout read request, held until scan_ack
//   scan_addr  in   [ADDR_W-1:0] scanout read address
//   scan_ack   out  one-cycle read-complete pulse
//   scan_data  out  [7:0] read byte, valid with scan_ack
//   mem_addr   out  [ADDR_W-1:0] memory address
//   mem_wdata  out  [7:0] memory write data
//   mem_we     out  memory write enable
//   mem_re     out  memory read enable
//   mem_rdata  in   [7:0] memory read data, valid one cycle after mem_re
//   fifo_full  out  write FIFO holds FIFO_DEPTH entries
//   overflow   out  sticky: a byte was dropped on a full FIFO
// -----------------------------------------------------------------------------
module vram_arbiter #(
    parameter int ADDR_W       = 19,
    parameter int FIFO_DEPTH   = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              sysclk,
    input  logic              rst,
    input  logic              cmdclk,
    input  logic [31:0]       address,
    input  logic              dataclk,
    input  logic [7:0]        data_in,
    input  logic              scan_req,
    input  logic [ADDR_W-1:0] scan_addr,
    output logic              scan_ack,
    output logic [7:0]        scan_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata,
    output logic              fifo_full,
    output logic              overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        RDONE = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t state, state_nxt;

    // Upper address bits are intentionally ignored.
    if (ADDR_W < 32) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^address[31:ADDR_W];
    end

    // ---------------------------------------------------------------
    // Write pointer and write FIFO
    // ---------------------------------------------------------------
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] addr_sel;
    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [7:0]        fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              fifo_empty;
    logic              push, pop;

    // A coincident cmdclk takes effect for the byte arriving in the same cycle.
    assign addr_sel   = cmdclk ? address[ADDR_W-1:0] : wptr;
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    // Acceptance depends only on the pre-edge fullness, so a same-cycle pop
    // does not make room for the incoming byte.
    assign push       = dataclk && !fifo_full;

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            wptr     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            // The pointer advances even when the byte is dropped.
            if (dataclk) begin
                wptr <= addr_sel + 1'b1;
            end else if (cmdclk) begin
                wptr <= address[ADDR_W-1:0];
            end
            if (dataclk && fifo_full) begin
                overflow <= 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage carries data only and needs no reset.
    always_ff @(posedge sysclk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= addr_sel;
            fifo_data[wr_ptr] <= data_in;
        end
    end

    // ---------------------------------------------------------------
    // Starvation guard
    // ---------------------------------------------------------------
    logic starve_force;

`ifdef VRAM_ARB_STARVE_GUARD_EN
    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    logic [SC_W-1:0] starve_cnt;

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (state == WRITE || fifo_empty) begin
            starve_cnt <= '0;
        end else if (state == RDONE && starve_cnt < SC_W'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign starve_force = (starve_cnt >= SC_W'(STARVE_LIMIT));
`else
    localparam int unused_starve_limit = STARVE_LIMIT;
    assign starve_force = 1'b0;
`endif

    // ---------------------------------------------------------------
    // Arbitration FSM: memory-side outputs are registered, so the
    // strobe for a state is computed on the transition into it.
    // ---------------------------------------------------------------
    logic              mem_re_d, mem_we_d, scan_ack_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [7:0]        mem_wdata_d, scan_data_d;

    always_comb begin
        state_nxt   = state;
        mem_re_d    = 1'b0;
        mem_we_d    = 1'b0;
        scan_ack_d  = 1'b0;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        scan_data_d = scan_data;
        pop         = 1'b0;
        case (state)
            IDLE: begin
                // During the ack cycle the requester still holds scan_req for
                // the read just retired; wait one cycle so it is not re-served.
                if (scan_ack) begin
                    state_nxt = IDLE;
                end else if (!fifo_empty && (starve_force || !scan_req)) begin
                    state_nxt   = WRITE;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = fifo_addr[rd_ptr];
                    mem_wdata_d = fifo_data[rd_ptr];
                    pop         = 1'b1;
                end else if (scan_req) begin
                    state_nxt  = READ;
                    mem_re_d   = 1'b1;
                    mem_addr_d = scan_addr;
                end
            end
            READ: begin
                state_nxt = RDONE;
            end
            RDONE: begin
                state_nxt   = IDLE;
                scan_ack_d  = 1'b1;
                scan_data_d = mem_rdata;
            end
            WRITE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            scan_ack  <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            scan_data <= '0;
        end else begin
            state     <= state_nxt;
            mem_re    <= mem_re_d;
            mem_we    <= mem_we_d;
            scan_ack  <= scan_ack_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            scan_data <= scan_data_d;
        end
    end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 19, sets the memory address width in bits.
REQ-002 Parameter FIFO_DEPTH, default 8, sets write FIFO entries; it SHALL be a power of two, at least 2.
REQ-003 Parameter STARVE_LIMIT, default 4, sets the maximum consecutive scan reads while writes are pending.
REQ-004 Port sysclk  in  1  is the single clock; all logic SHALL act on its rising edge.
REQ-005 Port rst  in  1  is the reset; it SHALL be asynchronous and active-high.
REQ-006 Port cmdclk  in  1  is a one-cycle strobe; when high, address is valid.
REQ-007 Port address  in  32  is the MCU start address; only bits [ADDR_W-1:0] are used.
REQ-008 Port dataclk  in  1  is a one-cycle strobe; when high, data_in is valid.
REQ-009 Port data_in  in  8  is the MCU pixel byte.
REQ-010 Port scan_req  in  1  is the scanout read request, held high until scan_ack.
REQ-011 Port scan_addr  in  ADDR_W  is the scanout read address, stable while scan_req is high.
REQ-012 Port scan_ack  out  1  is a one-cycle grant-complete pulse.
REQ-013 Port scan_data  out  8  is the read byte, valid while scan_ack is high.
REQ-014 Port mem_addr  out  ADDR_W, mem_wdata  out  8, mem_we  out  1 and mem_re  out  1 are the memory request ports.
REQ-015 Port mem_rdata  in  8  is the read data, valid one cycle after mem_re.
REQ-016 Port fifo_full  out  1  is high when the write FIFO holds FIFO_DEPTH entries.
REQ-017 Port overflow  out  1  is a sticky dropped-write flag.

Function
REQ-018 The write pointer wptr[ADDR_W-1:0] SHALL load address[ADDR_W-1:0] on cmdclk.
REQ-019 On dataclk, {wptr, data_in} SHALL be pushed to the FIFO and wptr SHALL increment by 1, wrapping from 2^ADDR_W-1 to 0.
REQ-020 If cmdclk and dataclk coincide, the pushed entry SHALL use the new address, and wptr SHALL become that address plus 1.
REQ-021 On dataclk with the FIFO full, the byte SHALL be dropped, overflow SHALL set, and wptr SHALL still increment.
REQ-022 A push and a pop in the same cycle on a full FIFO SHALL still drop the incoming byte.
REQ-023 The FSM SHALL have the states IDLE, READ, RDONE and WRITE.
REQ-024 In IDLE with scan_req high (and the starvation rule not forcing a write), the FSM SHALL go to READ.
REQ-025 In IDLE with scan_req low and the FIFO non-empty, the FSM SHALL go to WRITE.
REQ-026 In IDLE with neither condition, the FSM SHALL stay in IDLE.
REQ-027 In READ, mem_re SHALL be 1 and mem_addr SHALL equal scan_addr for one cycle, then the FSM SHALL go to RDONE.
REQ-028 In RDONE, scan_data SHALL capture mem_rdata and scan_ack SHALL pulse for one cycle, then the FSM SHALL go to IDLE.
REQ-029 Read latency, scan_req to scan_ack, SHALL be 3 cycles from IDLE.
REQ-030 In WRITE, mem_we SHALL be 1 with the FIFO head on mem_addr/mem_wdata for one cycle, the head SHALL be popped, and the FSM SHALL go to IDLE.
REQ-031 mem_we and mem_re SHALL never be high together.
REQ-032 mem_re and mem_we SHALL be 0 in all states except READ and WRITE respectively.
REQ-033 FIFO writes to memory SHALL occur in push order.

Reset
REQ-034 While rst is high: state SHALL be IDLE; FIFO empty; wptr=0; overflow=0; scan_ack, mem_we and mem_re =0; scan_data, mem_addr and mem_wdata =0; starvation counter =0.
REQ-035 Reset asserted mid-READ or mid-WRITE SHALL abort the access without an ack, and pending FIFO entries SHALL be lost.

Configuration
REQ-036 With VRAM_ARB_STARVE_GUARD_EN defined, a counter SHALL count completed reads while the FIFO is non-empty.
REQ-037 With VRAM_ARB_STARVE_GUARD_EN defined, once the counter reaches STARVE_LIMIT, IDLE SHALL go to WRITE even if scan_req is high.
REQ-038 With VRAM_ARB_STARVE_GUARD_EN defined, the counter SHALL clear on every WRITE or whenever the FIFO is empty.
REQ-039 Without VRAM_ARB_STARVE_GUARD_EN, scan reads SHALL have strict priority, and the counter logic SHALL be absent.

Verification
REQ-040 cmdclk with address=0x100, then 3 dataclk with 0xA1,0xA2,0xA3 and no scan_req -> writes at 0x100,0x101,0x102 in order; overflow=0.
REQ-041 scan_req, scan_addr=0x55, memory holding 0x7E -> mem_re 1 cycle later, scan_ack with scan_data=0x7E 3 cycles after the request.
REQ-042 9 back-to-back dataclk with scan_req held high, DEPTH=8, guard disabled -> fifo_full, 9th byte dropped, overflow=1; after scan_req drops, 8 writes occur.
REQ-043 Guard enabled, STARVE_LIMIT=4, continuous scan_req, 1 entry queued -> exactly 4 reads, then 1 write, then reads resume.
REQ-044 cmdclk with address=0x7FFFF and 2 dataclk -> writes at 0x7FFFF then 0x00000.
REQ-045 rst pulsed during WRITE with 3 entries queued -> no further mem_we, fifo empty, all outputs at reset values.
